// File: rtl/store_buffer_if.sv
// Store-buffer port bundle: store requests from MEM, load forwarding lookup,
// data-memory drain port and occupancy status.
interface store_buffer_if;
   logic        st_valid;
   logic [31:0] st_addr;
   logic [31:0] st_data;
   logic [31:0] st_pc;
   logic        st_ready;
   logic [31:0] ld_addr;
   logic        ld_hit;
   logic [31:0] ld_data;
   logic        dm_busy;
   logic        dm_we;
   logic [31:0] dm_addr;
   logic [31:0] dm_data;
   logic [31:0] dm_pc;
   logic        empty;
   logic [4:0]  count;

   modport master (
      output st_valid, st_addr, st_data, st_pc, ld_addr, dm_busy,
      input  st_ready, ld_hit, ld_data, dm_we, dm_addr, dm_data, dm_pc, empty, count
   );

   modport slave (
      input  st_valid, st_addr, st_data, st_pc, ld_addr, dm_busy,
      output st_ready, ld_hit, ld_data, dm_we, dm_addr, dm_data, dm_pc, empty, count
   );
endinterface

// File: rtl/store_buffer.sv
// Circular store buffer: accepts stores from MEM, drains them in program order
// to data memory when the port is free, and forwards the youngest match to loads.
module store_buffer #(
   parameter int DEPTH = 4
) (
   input logic          clk,
   input logic          rst,
   store_buffer_if.slave sb
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [29:0]   mem_addr [DEPTH];
   logic [31:0]   mem_data [DEPTH];
   logic [31:0]   mem_pc   [DEPTH];
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [4:0]    cnt;
   logic          push;
   logic          pop;
   logic          is_empty;
   logic          fwd_hit;
   logic [31:0]   fwd_data;
   logic [PW-1:0] idx;
   logic          unused_low_bits;

   // Byte offsets are irrelevant: entries and lookups are word granular.
   assign unused_low_bits = ^{sb.st_addr[1:0], sb.ld_addr[1:0]};

   assign is_empty    = (cnt == 5'd0);
   assign sb.st_ready = (cnt < 5'(DEPTH));
   assign push        = sb.st_valid && sb.st_ready;
   assign pop         = sb.dm_we;

   assign sb.empty   = is_empty;
   assign sb.count   = cnt;
   assign sb.dm_we   = !is_empty && !sb.dm_busy;
   assign sb.dm_addr = is_empty ? 32'd0 : {mem_addr[head], 2'b00};
   assign sb.dm_data = is_empty ? 32'd0 : mem_data[head];
   assign sb.dm_pc   = is_empty ? 32'd0 : mem_pc[head];
   assign sb.ld_hit  = fwd_hit;
   assign sb.ld_data = fwd_data;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         head <= '0;
         tail <= '0;
         cnt  <= 5'd0;
      end else begin
         if (push) tail <= tail + PW'(1);
         if (pop)  head <= head + PW'(1);
         cnt <= cnt + 5'(push) - 5'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && push) begin
         mem_addr[tail] <= sb.st_addr[31:2];
         mem_data[tail] <= sb.st_data;
         mem_pc[tail]   <= sb.st_pc;
      end
   end

   // Walk held entries oldest to youngest so the youngest match is left standing;
   // the head entry stays eligible even while it is being drained.
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = 32'd0;
      idx      = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = head + PW'(i);
         if ((5'(i) < cnt) && (mem_addr[idx] == sb.ld_addr[31:2])) begin
            fwd_hit  = 1'b1;
            fwd_data = mem_data[idx];
         end
      end
   end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: queue-based reference model compared
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_store_buffer;

   localparam int DEPTH = 4;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [31:0] pc;
   } entry_t;

   logic clk;
   logic rst;
   int   tests_run = 0;
   int   tests_failed = 0;
   bit   check_on = 0;

   entry_t model_q[$];
   entry_t wlog[$];

   store_buffer_if sb ();

   store_buffer #(.DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .sb  (sb.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic valid, input logic [31:0] addr, input logic [31:0] data,
                                input logic [31:0] pc, input logic busy, input logic [31:0] ld);
      sb.st_valid = valid;
      sb.st_addr  = addr;
      sb.st_data  = data;
      sb.st_pc    = pc;
      sb.dm_busy  = busy;
      sb.ld_addr  = ld;
   endtask

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   // Reference model: a plain queue, oldest entry at index 0.
   always @(posedge clk) begin
      bit do_pop, do_push;
      entry_t e;
      do_pop  = (model_q.size() > 0) && !sb.dm_busy;
      do_push = sb.st_valid && (model_q.size() < DEPTH);
      if (rst) begin
         model_q.delete();
      end else begin
         if (do_pop) void'(model_q.pop_front());
         if (do_push) begin
            e.addr = {sb.st_addr[31:2], 2'b00};
            e.data = sb.st_data;
            e.pc   = sb.st_pc;
            model_q.push_back(e);
         end
      end
   end

   // Per-cycle comparison against the model, and a log of memory writes seen.
   initial begin
      @(posedge clk);
      forever begin
         @(negedge clk);
         if (check_on) begin
            logic        exp_hit;
            logic [31:0] exp_ld;
            int          n;
            entry_t      w;
            n = model_q.size();
            exp_hit = 1'b0;
            exp_ld  = 32'd0;
            for (int i = n - 1; i >= 0; i--) begin
               if (!exp_hit && model_q[i].addr[31:2] == sb.ld_addr[31:2]) begin
                  exp_hit = 1'b1;
                  exp_ld  = model_q[i].data;
               end
            end
            checkOutput("st_ready", 32'(sb.st_ready), 32'(n < DEPTH));
            checkOutput("empty",    32'(sb.empty),    32'(n == 0));
            checkOutput("count",    32'(sb.count),    32'(n));
            checkOutput("count_le_depth", 32'(sb.count <= 5'(DEPTH)), 32'd1);
            checkOutput("dm_we",    32'(sb.dm_we),    32'((n > 0) && !sb.dm_busy));
            checkOutput("dm_addr",  sb.dm_addr, (n > 0) ? model_q[0].addr : 32'd0);
            checkOutput("dm_data",  sb.dm_data, (n > 0) ? model_q[0].data : 32'd0);
            checkOutput("dm_pc",    sb.dm_pc,   (n > 0) ? model_q[0].pc   : 32'd0);
            checkOutput("ld_hit",   32'(sb.ld_hit), 32'(exp_hit));
            checkOutput("ld_data",  sb.ld_data, exp_ld);
            if (sb.dm_we && !rst) begin
               w.addr = sb.dm_addr;
               w.data = sb.dm_data;
               w.pc   = sb.dm_pc;
               wlog.push_back(w);
            end
         end
      end
   end

   initial begin
      int  idx;
      int  cyc;
      bit  busy;
      bit  accepted;

      rst = 1'b1;
      applyStimulus(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0);
      stepCycle();
      stepCycle();
      rst = 1'b0;
      check_on = 1;

      $display("[TB] reset state");
      @(negedge clk);
      checkOutput("rst_st_ready", 32'(sb.st_ready), 32'd1);
      checkOutput("rst_empty",    32'(sb.empty),    32'd1);
      checkOutput("rst_count",    32'(sb.count),    32'd0);
      checkOutput("rst_dm_we",    32'(sb.dm_we),    32'd0);
      checkOutput("rst_dm_addr",  sb.dm_addr,       32'd0);
      checkOutput("rst_ld_hit",   32'(sb.ld_hit),   32'd0);
      stepCycle();

      $display("[TB] basic push and drain");
      wlog.delete();
      applyStimulus(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0400, 1'b0, 32'h0000_0010);
      @(negedge clk);
      checkOutput("basic_no_bypass_we", 32'(sb.dm_we),  32'd0);
      checkOutput("basic_no_same_fwd",  32'(sb.ld_hit), 32'd0);
      stepCycle();
      applyStimulus(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 32'h0000_0010);
      @(negedge clk);
      checkOutput("basic_dm_we",   32'(sb.dm_we), 32'd1);
      checkOutput("basic_dm_addr", sb.dm_addr,    32'h0000_0010);
      checkOutput("basic_dm_data", sb.dm_data,    32'hDEAD_BEEF);
      checkOutput("basic_dm_pc",   sb.dm_pc,      32'h0000_0400);
      checkOutput("basic_pop_fwd", sb.ld_data,    32'hDEAD_BEEF);
      stepCycle();
      @(negedge clk);
      checkOutput("basic_empty_after", 32'(sb.empty), 32'd1);
      checkOutput("basic_one_write",   32'(wlog.size()), 32'd1);
      stepCycle();

      $display("[TB] full and backpressure");
      wlog.delete();
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 32'h100 + 32'(4 * i), 32'hA0 + 32'(i), 32'h1000 + 32'(i), 1'b1, 32'd0);
         stepCycle();
      end
      applyStimulus(1'b1, 32'h200, 32'hBAD, 32'h2000, 1'b1, 32'd0);
      @(negedge clk);
      checkOutput("full_count",    32'(sb.count),    32'd4);
      checkOutput("full_st_ready", 32'(sb.st_ready), 32'd0);
      stepCycle();
      applyStimulus(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0);
      repeat (4) stepCycle();
      @(negedge clk);
      checkOutput("full_drained_empty", 32'(sb.empty), 32'd1);
      checkOutput("full_write_count",   32'(wlog.size()), 32'd4);
      for (int i = 0; i < 4; i++) begin
         if (i < wlog.size()) begin
            checkOutput("full_order_addr", wlog[i].addr, 32'h100 + 32'(4 * i));
            checkOutput("full_order_data", wlog[i].data, 32'hA0 + 32'(i));
         end
      end
      stepCycle();

      $display("[TB] forwarding youngest match");
      applyStimulus(1'b1, 32'h20, 32'h1111_1111, 32'h500, 1'b1, 32'd0);
      stepCycle();
      applyStimulus(1'b1, 32'h20, 32'h2222_2222, 32'h504, 1'b1, 32'd0);
      stepCycle();
      applyStimulus(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 32'h23);
      @(negedge clk);
      checkOutput("fwd_hit",  32'(sb.ld_hit), 32'd1);
      checkOutput("fwd_data", sb.ld_data,     32'h2222_2222);
      sb.ld_addr = 32'h24;
      #1;
      checkOutput("fwd_miss_hit",  32'(sb.ld_hit), 32'd0);
      checkOutput("fwd_miss_data", sb.ld_data,     32'd0);
      stepCycle();
      applyStimulus(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0);
      repeat (3) stepCycle();

      $display("[TB] wrap with toggling drain");
      wlog.delete();
      idx  = 0;
      cyc  = 0;
      busy = 1'b0;
      while (idx < 10 && cyc < 100) begin
         applyStimulus(1'b1, 32'h300 + 32'(4 * idx), 32'hC000 + 32'(idx), 32'h3000 + 32'(idx), busy, 32'd0);
         @(negedge clk);
         accepted = sb.st_ready;
         stepCycle();
         if (accepted) idx++;
         busy = !busy;
         cyc++;
      end
      checkOutput("wrap_all_accepted", 32'(idx), 32'd10);
      applyStimulus(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (sb.empty) break;
         stepCycle();
      end
      checkOutput("wrap_drained_empty", 32'(sb.empty), 32'd1);
      checkOutput("wrap_write_count",   32'(wlog.size()), 32'd10);
      for (int i = 0; i < 10; i++) begin
         if (i < wlog.size()) begin
            checkOutput("wrap_order_addr", wlog[i].addr, 32'h300 + 32'(4 * i));
            checkOutput("wrap_order_data", wlog[i].data, 32'hC000 + 32'(i));
         end
      end
      stepCycle();

      $display("[TB] reset mid-operation");
      wlog.delete();
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 32'h700 + 32'(4 * i), 32'hE0 + 32'(i), 32'h7000 + 32'(i), 1'b1, 32'd0);
         stepCycle();
      end
      applyStimulus(1'b1, 32'h800, 32'hF00D, 32'h8000, 1'b1, 32'h700);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("midrst_held_count", 32'(sb.count), 32'd3);
      stepCycle();
      rst = 1'b0;
      applyStimulus(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 32'h700);
      @(negedge clk);
      checkOutput("midrst_count",    32'(sb.count),    32'd0);
      checkOutput("midrst_st_ready", 32'(sb.st_ready), 32'd1);
      checkOutput("midrst_dm_we",    32'(sb.dm_we),    32'd0);
      checkOutput("midrst_ld_hit",   32'(sb.ld_hit),   32'd0);
      repeat (4) stepCycle();
      @(negedge clk);
      checkOutput("midrst_no_writes", 32'(wlog.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameter: DEPTH, default 4, number of buffered store entries; power of 2, range 2..16.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset: clk in 1, rising-edge clock; rst in 1, synchronous active-high reset.
REQ-003 Port: st_valid  in  1  store request from MEM stage.
REQ-004 Port: st_addr  in  32  store byte address; bits [1:0] ignored, stored as 00.
REQ-005 Port: st_data  in  32  store word.
REQ-006 Port: st_pc  in  32  PC of storing instruction, carried for trace.
REQ-007 Port: st_ready  out  1  buffer can accept a store this cycle.
REQ-008 Port: ld_addr  in  32  load byte address for forwarding lookup.
REQ-009 Port: ld_hit  out  1  a held entry matches ld_addr[31:2].
REQ-010 Port: ld_data  out  32  data of youngest matching entry; 0 when no hit.
REQ-011 Port: dm_busy  in  1  data-memory port claimed by a load this cycle; drain suppressed.
REQ-012 Port: dm_we  out  1  write strobe to data memory.
REQ-013 Port: dm_addr  out  32  head-entry word address to data memory.
REQ-014 Port: dm_data  out  32  head-entry data to data memory.
REQ-015 Port: dm_pc  out  32  head-entry PC to data memory.
REQ-016 Port: empty  out  1  no entries held.
REQ-017 Port: count  out  5  number of held entries, 0..DEPTH.

Function
REQ-018 Storage SHALL be a circular FIFO of DEPTH entries {addr[31:2], data, pc}, with head/tail pointers wrapping modulo DEPTH.
REQ-019 st_ready SHALL equal (count < DEPTH); it SHALL NOT depend on a same-cycle drain.
REQ-020 Push: on a rising edge with st_valid=1 and st_ready=1, the entry SHALL be written at tail, tail SHALL advance by 1, and count SHALL increase by 1.
REQ-021 st_valid with st_ready=0 SHALL be ignored, with no state change; upstream holds the request.
REQ-022 dm_we SHALL be combinational: !empty && !dm_busy. dm_addr, dm_data and dm_pc SHALL reflect the head entry whenever !empty, and be 0 when empty.
REQ-023 Pop: on a rising edge with dm_we=1, head SHALL advance by 1 and count SHALL decrease by 1.
REQ-024 Simultaneous push and pop SHALL leave count unchanged; both pointers advance.
REQ-025 An accepted store SHALL appear on the dm_* port no earlier than the cycle after acceptance; there is no same-cycle bypass from st_* to dm_*.
REQ-026 Drain order SHALL be strict FIFO (program order).
REQ-027 Forwarding SHALL be combinational over held entries only, comparing ld_addr[31:2] with entry addr[31:2].
REQ-028 When several entries match, the youngest (closest to tail) SHALL win.
REQ-029 An entry being popped in the current cycle SHALL still be eligible for a hit in that cycle.
REQ-030 A store accepted in the current cycle SHALL NOT be forwarded in that cycle.
REQ-031 count SHALL never exceed DEPTH or underflow below 0; empty SHALL equal (count==0).

Reset
REQ-032 When rst=1 at a rising edge, head, tail and count SHALL be set to 0, and all pending entries SHALL be discarded without being written to memory.
REQ-033 rst SHALL take priority over push and pop in the same cycle.
REQ-034 Outputs after reset SHALL be: st_ready=1, empty=1, count=0, dm_we=0, dm_addr/dm_data/dm_pc=0, ld_hit=0, ld_data=0.

Verification
REQ-035 Basic: push addr 0x0000_0010 data 0xDEADBEEF with dm_busy=0 -> next cycle dm_we=1, dm_addr=0x10, dm_data=0xDEADBEEF; following cycle empty=1.
REQ-036 Full/backpressure: hold dm_busy=1 and push 4 stores -> count=4, st_ready=0; a 5th st_valid is ignored; release dm_busy -> 4 writes in push order, then empty=1.
REQ-037 Forwarding: buffer stores to 0x20 (0x11111111) then 0x20 (0x22222222) with dm_busy=1; ld_addr=0x23 -> ld_hit=1, ld_data=0x22222222; ld_addr=0x24 -> ld_hit=0, ld_data=0.
REQ-038 Wrap and concurrency: 10 back-to-back pushes with dm_busy toggling every cycle -> every store drained exactly once in order, pointers wrap, count never exceeds 4.
REQ-039 Reset mid-operation: 3 entries held, assert rst together with st_valid=1 -> next cycle count=0, st_ready=1, dm_we=0, and no discarded store ever appears on dm_*.
